regfile_wb_queue: RTL
=====================

Name: regfile_wb_queue

Overview:
- Writer-side front end for the 32x32 register file: it drives the file's write port (Wr, D, We).
- Accepts up to two writeback results per cycle, one from the ALU and one from the memory load path, and queues them in program order.
- Drains one entry per cycle into the register file.
- Provides read-port forwarding for pending writes, so decode never reads a stale value.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Clrn  in  1  asynchronous active-low reset.
- mem_we  in  1  load-result write request (older instruction).
- mem_wr  in  AW  load destination register.
- mem_d  in  DW  load data.
- alu_we  in  1  ALU-result write request (younger instruction).
- alu_wr  in  AW  ALU destination register.
- alu_d  in  DW  ALU data.
- full  out  1  stall to pipeline; fewer than 2 free slots.
- ovf  out  1  sticky: a request arrived while full.
- Ra  in  AW  decode read address A (same value as the register-file Ra).
- Rb  in  AW  decode read address B.
- fwd_a_hit  out  1  a pending write to Ra exists.
- fwd_a_val  out  DW  newest pending data for Ra.
- fwd_b_hit  out  1  a pending write to Rb exists.
- fwd_b_val  out  DW  newest pending data for Rb.
- Wr  out  AW  register-file write address.
- D  out  DW  register-file write data.
- We  out  1  register-file write enable.
- empty  out  1  queue and output stage both idle.

Behaviour:
- Reset (Clrn=0, asynchronous):
  - Queue pointers and count go to 0; all entry valids clear.
  - Wr=0, D=0, We=0, ovf=0, full=0, empty=1.
  - Reset mid-operation discards all pending writes; nothing partial reaches the register file.
- Storage: circular buffer of DEPTH entries {wr, d}, with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Count is $clog2(DEPTH+1) bits.
- full is combinational from the registered count: full = (count > DEPTH-2).
- Enqueue at posedge, only when full=0:
  - Writes with wr=0 are dropped (never enqueued, never forwarded), so r0 stays zero.
  - If both requests are valid, the mem entry goes in at tail and the alu entry at tail+1, preserving program order.
  - If only one is valid, it goes in at tail; tail advances by the number of accepted entries (0, 1 or 2).
- Overflow: any valid request (wr!=0) while full=1 is discarded and sets ovf=1. ovf holds until reset.
- Drain: at each posedge, if count>0 (using pre-edge count):
  - Head is popped.
  - The output register loads Wr=head.wr, D=head.d, We=1.
  - Otherwise We=0; Wr and D hold their previous values.
- Latency:
  - A request presented before posedge N is enqueued at N and reaches the output register (We=1) at N+1 at the earliest.
  - The register file captures it at the negedge within cycle N+1.
  - Throughput is 1 write per cycle.
- Simultaneous push and pop: allowed on the same edge. count_next = count + pushes - pop, never exceeding DEPTH because full gates pushes.
- Forwarding (combinational):
  - Search covers the valid queue entries plus the output register while We=1.
  - Priority: newest queue entry (closest to tail) first, then older entries, then the output register.
  - Inputs presented in the current cycle are not forwarded. The pipeline must stall one cycle for a same-cycle dependency.
  - Ra=0 or Rb=0 never hits.
  - On a miss, fwd_x_val=0.
- empty = (count==0) && !We.

Decomposition:
- Shared package cpu_pkg holds: AW and DW defaults; REG_ZERO = 0; the typedef wb_entry_t {logic [AW-1:0] wr; logic [DW-1:0] d}.
- Sub-module wb_fwd_match: combinational newest-first priority matcher over the DEPTH entries plus the output stage. It is instantiated twice, for ports A and B.

Test Plan:
1. Reset, then alu_we=1, alu_wr=3, alu_d=0x11 for one cycle. Required: We=1, Wr=3, D=0x11 exactly one cycle later, then We=0 and empty=1.
2. Same cycle mem(wr=5, d=0xAA) and alu(wr=5, d=0xBB). Required: two consecutive writes, 0xAA then 0xBB; fwd on Ra=5 shows 0xBB while both are pending, and 0xAA never shows after the alu entry is queued.
3. Fill with 2-per-cycle writes to r1..r4. Required: full=1 when count>=3. A further alu write while full sets ovf=1 and is never emitted; drain order is r1, r2, r3, r4.
4. alu write to r0 with d=0xFF. Required: no enqueue, We stays 0, and fwd on Ra=0 gives hit=0.
5. Three queued writes to r7 (values 1, 2, 3) with Ra=7. Required: fwd_a_val=3 until the last write retires on We, then fwd_a_hit=0.
6. Clrn pulsed low with 3 entries pending and We=1. Required: We=0 and empty=1 immediately, with no further writes after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: register-file geometry and the
// writeback entry record queued in front of the register file.
package cpu_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  localparam logic [AW_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW_DEF-1:0] wr;
    logic [DW_DEF-1:0] d;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Pipeline-facing bundle of the writeback queue: two writeback request ports,
// decode read-port forwarding, and the register-file write port.
interface regfile_wb_queue_if #(
  parameter int AW = cpu_pkg::AW_DEF,
  parameter int DW = cpu_pkg::DW_DEF
);

  logic          mem_we;
  logic [AW-1:0] mem_wr;
  logic [DW-1:0] mem_d;
  logic          alu_we;
  logic [AW-1:0] alu_wr;
  logic [DW-1:0] alu_d;
  logic          full;
  logic          ovf;
  logic [AW-1:0] Ra;
  logic [AW-1:0] Rb;
  logic          fwd_a_hit;
  logic [DW-1:0] fwd_a_val;
  logic          fwd_b_hit;
  logic [DW-1:0] fwd_b_val;
  logic [AW-1:0] Wr;
  logic [DW-1:0] D;
  logic          We;
  logic          empty;

  modport master (
    output mem_we, mem_wr, mem_d,
    output alu_we, alu_wr, alu_d,
    output Ra, Rb,
    input  full, ovf,
    input  fwd_a_hit, fwd_a_val, fwd_b_hit, fwd_b_val,
    input  Wr, D, We, empty
  );

  modport slave (
    input  mem_we, mem_wr, mem_d,
    input  alu_we, alu_wr, alu_d,
    input  Ra, Rb,
    output full, ovf,
    output fwd_a_hit, fwd_a_val, fwd_b_hit, fwd_b_val,
    output Wr, D, We, empty
  );

endinterface

// File: rtl/wb_fwd_match.sv
// Newest-first match of one read address against pending queue entries
// and the register-file output stage.
module wb_fwd_match
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic [AW-1:0]             ra,
  input  logic [DEPTH-1:0][AW-1:0]  q_wr,
  input  logic [DEPTH-1:0][DW-1:0]  q_d,
  input  logic [DEPTH-1:0]          q_v,
  input  logic [$clog2(DEPTH)-1:0]  tail,
  input  logic                      out_we,
  input  logic [AW-1:0]             out_wr,
  input  logic [DW-1:0]             out_d,
  output logic                      hit,
  output logic [DW-1:0]             val
);

  localparam int PW = $clog2(DEPTH);

  // Walk from oldest to newest so later (younger) matches overwrite earlier ones;
  // the output stage is the oldest of all and is applied first.
  always_comb begin
    logic [PW-1:0] idx;
    hit = 1'b0;
    val = '0;
    idx = '0;
    if (out_we && (out_wr == ra)) begin
      hit = 1'b1;
      val = out_d;
    end
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PW'(k);
      if (q_v[idx] && (q_wr[idx] == ra)) begin
        hit = 1'b1;
        val = q_d[idx];
      end
    end
    if (ra == AW'(REG_ZERO)) begin
      hit = 1'b0;
      val = '0;
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register file: accepts mem+alu results in
// program order, drains one per cycle to Wr/D/We, and forwards pending data.
module regfile_wb_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input logic               Clk,
  input logic               Clrn,
  regfile_wb_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][AW-1:0] q_wr;
  logic [DEPTH-1:0][DW-1:0] q_d;
  logic [DEPTH-1:0]         q_v;
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [PW-1:0]            alu_slot;
  logic [CW-1:0]            count;
  logic [CW-1:0]            n_push;
  logic                     full;
  logic                     pop;
  logic                     mem_ok;
  logic                     alu_ok;
  logic                     push_mem;
  logic                     push_alu;
  logic                     ovf;
  logic                     we_r;
  logic [AW-1:0]            wr_r;
  logic [DW-1:0]            d_r;

  // Two free slots are needed because both ports may push on the same edge.
  assign full     = (count > CW'(DEPTH - 2));
  assign mem_ok   = bus.mem_we && (bus.mem_wr != AW'(REG_ZERO));
  assign alu_ok   = bus.alu_we && (bus.alu_wr != AW'(REG_ZERO));
  assign push_mem = mem_ok && !full;
  assign push_alu = alu_ok && !full;
  assign pop      = (count != '0);
  assign n_push   = CW'(push_mem) + CW'(push_alu);
  assign alu_slot = push_mem ? (tail + PW'(1)) : tail;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      q_v   <= '0;
      q_wr  <= '0;
      q_d   <= '0;
      we_r  <= 1'b0;
      wr_r  <= '0;
      d_r   <= '0;
      ovf   <= 1'b0;
    end else begin
      if (pop) begin
        we_r       <= 1'b1;
        wr_r       <= q_wr[head];
        d_r        <= q_d[head];
        q_v[head]  <= 1'b0;
        head       <= head + PW'(1);
      end else begin
        we_r <= 1'b0;
      end
      // The mem result belongs to the older instruction, so it takes the lower slot.
      if (push_mem) begin
        q_wr[tail] <= bus.mem_wr;
        q_d[tail]  <= bus.mem_d;
        q_v[tail]  <= 1'b1;
      end
      if (push_alu) begin
        q_wr[alu_slot] <= bus.alu_wr;
        q_d[alu_slot]  <= bus.alu_d;
        q_v[alu_slot]  <= 1'b1;
      end
      tail  <= tail + n_push[PW-1:0];
      count <= count + n_push - CW'(pop);
      if ((mem_ok || alu_ok) && full) begin
        ovf <= 1'b1;
      end
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_a (
    .ra     (bus.Ra),
    .q_wr   (q_wr),
    .q_d    (q_d),
    .q_v    (q_v),
    .tail   (tail),
    .out_we (we_r),
    .out_wr (wr_r),
    .out_d  (d_r),
    .hit    (bus.fwd_a_hit),
    .val    (bus.fwd_a_val)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_b (
    .ra     (bus.Rb),
    .q_wr   (q_wr),
    .q_d    (q_d),
    .q_v    (q_v),
    .tail   (tail),
    .out_we (we_r),
    .out_wr (wr_r),
    .out_d  (d_r),
    .hit    (bus.fwd_b_hit),
    .val    (bus.fwd_b_val)
  );

  assign bus.full  = full;
  assign bus.ovf   = ovf;
  assign bus.Wr    = wr_r;
  assign bus.D     = d_r;
  assign bus.We    = we_r;
  assign bus.empty = (count == '0) && !we_r;

endmodule
